cell_write_arbiter: RTL and testbench

Per-cell write arbiter for the multi-port memory. It sits directly downstream of the per-cell `write_collision` monitor. It resolves simultaneous writes from several agents to one cell with a round-robin policy and stores the winning data. It acknowledges the winner, rejects the losers, and keeps collision statistics (saturating counter plus sticky flag) for the cell.

---
 rtl/cell_write_arbiter.sv | 141 ++++++++++++++
 tb/tb_cell_write_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_write_arbiter.sv
// rtl/cell_write_arbiter.sv - per-cell round-robin write arbiter with collision statistics
// Registered cell storage, one-cycle ack/nack pulses and a saturating multi-hit counter.
module cell_write_arbiter #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int NB_WRAGENT = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [ADDR_WIDTH-1:0]            cell_addr,
  input  logic [NB_WRAGENT-1:0]            wren,
  input  logic [NB_WRAGENT*ADDR_WIDTH-1:0] wraddr,
  input  logic [NB_WRAGENT*DATA_WIDTH-1:0] wrdata,
  input  logic                             collision,
  input  logic                             clr_stat,
  output logic [DATA_WIDTH-1:0]            cell_data,
  output logic                             cell_valid,
  output logic [NB_WRAGENT-1:0]            wrack,
  output logic [NB_WRAGENT-1:0]            wrnack,
  output logic [CNT_WIDTH-1:0]             coll_cnt,
  output logic                             coll_sticky
);

  localparam int PTR_W = $clog2(NB_WRAGENT);
  localparam logic [PTR_W-1:0] LAST_AGENT = PTR_W'(NB_WRAGENT - 1);

  logic [DATA_WIDTH-1:0] cell_data_q, cell_data_d;
  logic                  cell_valid_q, cell_valid_d;
  logic [NB_WRAGENT-1:0] wrack_q, wrack_d;
  logic [NB_WRAGENT-1:0] wrnack_q, wrnack_d;
  logic [CNT_WIDTH-1:0]  coll_cnt_q, coll_cnt_d;
  logic                  coll_sticky_q, coll_sticky_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;

  logic [NB_WRAGENT-1:0] hit;
  logic                  any_hit;
  logic                  multi_hit;
  logic                  hi_found;
  logic [PTR_W-1:0]      win_any;
  logic [PTR_W-1:0]      win_hi;
  logic [PTR_W-1:0]      winner;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  coll_seen;
  logic                  coll_event;

  // Downward scan: the lowest hit overall and the lowest hit at or above
  // rr_ptr are both kept; the latter wins, the former covers the wrap.
  always_comb begin
    hit       = '0;
    any_hit   = 1'b0;
    multi_hit = 1'b0;
    hi_found  = 1'b0;
    win_any   = '0;
    win_hi    = '0;
    for (int i = NB_WRAGENT - 1; i >= 0; i--) begin
      hit[i] = wren[i] && (wraddr[i*ADDR_WIDTH +: ADDR_WIDTH] == cell_addr);
      if (hit[i]) begin
        if (any_hit) begin
          multi_hit = 1'b1;
        end
        any_hit = 1'b1;
        win_any = PTR_W'(i);
        if (PTR_W'(i) >= rr_ptr_q) begin
          hi_found = 1'b1;
          win_hi   = PTR_W'(i);
        end
      end
    end
    winner = hi_found ? win_hi : win_any;
  end

  always_comb begin
    win_data = '0;
    wrack_d  = '0;
    wrnack_d = '0;
    for (int i = 0; i < NB_WRAGENT; i++) begin
      if (any_hit && (PTR_W'(i) == winner)) begin
        win_data   = wrdata[i*DATA_WIDTH +: DATA_WIDTH];
        wrack_d[i] = 1'b1;
      end else begin
        wrnack_d[i] = hit[i];
      end
    end
  end

  // The upstream collision flag can only confirm what the hit popcount shows;
  // the popcount is authoritative, so an inconsistent flag never counts.
  assign coll_seen  = collision & multi_hit;
  assign coll_event = multi_hit | coll_seen;

  always_comb begin
    cell_data_d   = cell_data_q;
    cell_valid_d  = cell_valid_q;
    rr_ptr_d      = rr_ptr_q;
    coll_cnt_d    = coll_cnt_q;
    coll_sticky_d = coll_sticky_q;
    if (any_hit) begin
      cell_data_d  = win_data;
      cell_valid_d = 1'b1;
      rr_ptr_d     = (winner == LAST_AGENT) ? '0 : winner + PTR_W'(1);
    end
    if (clr_stat) begin
      coll_cnt_d    = '0;
      coll_sticky_d = 1'b0;
    end else if (coll_event) begin
      coll_sticky_d = 1'b1;
      if (coll_cnt_q != {CNT_WIDTH{1'b1}}) begin
        coll_cnt_d = coll_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cell_data_q   <= '0;
      cell_valid_q  <= 1'b0;
      wrack_q       <= '0;
      wrnack_q      <= '0;
      coll_cnt_q    <= '0;
      coll_sticky_q <= 1'b0;
      rr_ptr_q      <= '0;
    end else begin
      cell_data_q   <= cell_data_d;
      cell_valid_q  <= cell_valid_d;
      wrack_q       <= wrack_d;
      wrnack_q      <= wrnack_d;
      coll_cnt_q    <= coll_cnt_d;
      coll_sticky_q <= coll_sticky_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  assign cell_data   = cell_data_q;
  assign cell_valid  = cell_valid_q;
  assign wrack       = wrack_q;
  assign wrnack      = wrnack_q;
  assign coll_cnt    = coll_cnt_q;
  assign coll_sticky = coll_sticky_q;

endmodule

// File: tb/tb_cell_write_arbiter.sv
// tb/tb_cell_write_arbiter.sv - directed and randomized bench for cell_write_arbiter
// Expected values come from a behavioural model of the arbitration rules.
module tb_cell_write_arbiter;

  localparam int NA = 2;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam int CW = 2;
  localparam logic [AW-1:0] CELL = 3'd5;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic             aclk;
  logic             aresetn;
  logic [AW-1:0]    cell_addr;
  logic [NA-1:0]    wren;
  logic [NA*AW-1:0] wraddr;
  logic [NA*DW-1:0] wrdata;
  logic             collision;
  logic             clr_stat;
  logic [DW-1:0]    cell_data;
  logic             cell_valid;
  logic [NA-1:0]    wrack;
  logic [NA-1:0]    wrnack;
  logic [CW-1:0]    coll_cnt;
  logic             coll_sticky;

  int checks = 0;
  int errors = 0;

  int          m_ptr;
  int          m_data;
  int          m_valid;
  int          m_ack;
  int          m_nack;
  int          m_cnt;
  int          m_sticky;

  cell_write_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NB_WRAGENT(NA),
    .CNT_WIDTH (CW)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .cell_addr  (cell_addr),
    .wren       (wren),
    .wraddr     (wraddr),
    .wrdata     (wrdata),
    .collision  (collision),
    .clr_stat   (clr_stat),
    .cell_data  (cell_data),
    .cell_valid (cell_valid),
    .wrack      (wrack),
    .wrnack     (wrnack),
    .coll_cnt   (coll_cnt),
    .coll_sticky(coll_sticky)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr    = 0;
    m_data   = 0;
    m_valid  = 0;
    m_ack    = 0;
    m_nack   = 0;
    m_cnt    = 0;
    m_sticky = 0;
  endtask

  // Winner = first hitting agent found walking from the pointer, modulo NA.
  task automatic model_step(input logic [NA-1:0] we, input int a[NA], input int d[NA], input logic clr);
    int nh;
    int win;
    int j;
    nh  = 0;
    win = -1;
    for (int k = 0; k < NA; k++) begin
      j = (m_ptr + k) % NA;
      if (we[j] && a[j] == int'(CELL)) begin
        nh++;
        if (win < 0) win = j;
      end
    end
    m_ack  = 0;
    m_nack = 0;
    if (nh > 0) begin
      m_data  = d[win];
      m_valid = 1;
      m_ptr   = (win + 1) % NA;
      for (int i = 0; i < NA; i++) begin
        if (we[i] && a[i] == int'(CELL)) begin
          if (i == win) m_ack  = m_ack  | (1 << i);
          else          m_nack = m_nack | (1 << i);
        end
      end
    end
    if (clr) begin
      m_cnt    = 0;
      m_sticky = 0;
    end else if (nh >= 2) begin
      m_sticky = 1;
      if (m_cnt < CNT_MAX) m_cnt++;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data"},   32'(cell_data),   32'(m_data));
    chk({tag, ".valid"},  32'(cell_valid),  32'(m_valid));
    chk({tag, ".wrack"},  32'(wrack),       32'(m_ack));
    chk({tag, ".wrnack"}, 32'(wrnack),      32'(m_nack));
    chk({tag, ".cnt"},    32'(coll_cnt),    32'(m_cnt));
    chk({tag, ".sticky"}, 32'(coll_sticky), 32'(m_sticky));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".data"},   32'(cell_data),   32'h0);
    chk({tag, ".valid"},  32'(cell_valid),  32'h0);
    chk({tag, ".wrack"},  32'(wrack),       32'h0);
    chk({tag, ".wrnack"}, 32'(wrnack),      32'h0);
    chk({tag, ".cnt"},    32'(coll_cnt),    32'h0);
    chk({tag, ".sticky"}, 32'(coll_sticky), 32'h0);
  endtask

  // Called at a falling edge: drive, advance the model, sample 1 after the rising edge.
  task automatic apply(input logic [NA-1:0] we, input int a0, input int a1, input int d0, input int d1,
                       input logic clr, input logic coll, input string tag);
    int a[NA];
    int d[NA];
    a[0] = a0;
    a[1] = a1;
    d[0] = d0;
    d[1] = d1;
    wren      = we;
    wraddr    = {AW'(a1), AW'(a0)};
    wrdata    = {DW'(d1), DW'(d0)};
    clr_stat  = clr;
    collision = coll;
    model_step(we, a, d, clr);
    @(posedge aclk);
    #1;
    check_all(tag);
    @(negedge aclk);
  endtask

  initial begin
    int ra;
    int rb;
    cell_addr = CELL;
    aresetn   = 1'b0;
    wren      = '0;
    wraddr    = '0;
    wrdata    = '0;
    collision = 1'b0;
    clr_stat  = 1'b0;
    model_reset();

    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      wren      = 2'($urandom);
      wraddr    = 6'($urandom);
      wrdata    = 16'($urandom);
      collision = 1'($urandom);
      clr_stat  = 1'($urandom);
    end
    #1;
    check_zero("reset_hold");
    @(negedge aclk);
    aresetn = 1'b1;
    apply(2'b00, 5, 5, 0, 0, 1'b0, 1'b0, "idle0");
    apply(2'b00, 5, 5, 8'hFF, 8'hFF, 1'b0, 1'b0, "idle1");

    apply(2'b01, 5, 0, 8'hA5, 0, 1'b0, 1'b0, "single0");
    chk("single0.const_data", 32'(cell_data), 32'hA5);
    chk("single0.const_ack", 32'(wrack), 32'h1);

    apply(2'b11, 5, 5, 8'h11, 8'h22, 1'b0, 1'b1, "coll_a");
    chk("coll_a.const_data", 32'(cell_data), 32'h22);
    chk("coll_a.const_nack", 32'(wrnack), 32'h1);
    apply(2'b11, 5, 5, 8'h11, 8'h22, 1'b0, 1'b1, "coll_b");
    chk("coll_b.const_data", 32'(cell_data), 32'h11);
    chk("coll_b.const_cnt", 32'(coll_cnt), 32'h2);

    apply(2'b11, 4, 6, 8'h77, 8'h88, 1'b0, 1'b1, "miss");
    chk("miss.const_data", 32'(cell_data), 32'h11);

    apply(2'b10, 0, 5, 8'h00, 8'h5A, 1'b0, 1'b1, "inconsistent");
    chk("inconsistent.const_cnt", 32'(coll_cnt), 32'h2);

    for (int i = 0; i < 5; i++) begin
      apply(2'b11, 5, 5, 8'h30 + i, 8'h40 + i, 1'b0, 1'b1, "sat");
    end
    chk("sat.const_cnt", 32'(coll_cnt), 32'h3);
    apply(2'b11, 5, 5, 8'h55, 8'h66, 1'b1, 1'b1, "clr_coll");
    chk("clr_coll.const_cnt", 32'(coll_cnt), 32'h0);
    chk("clr_coll.const_sticky", 32'(coll_sticky), 32'h0);

    for (int i = 0; i < 300; i++) begin
      ra = ($urandom_range(0, 3) < 3) ? 5 : int'($urandom_range(0, 7));
      rb = ($urandom_range(0, 3) < 3) ? 5 : int'($urandom_range(0, 7));
      apply(2'($urandom), ra, rb, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            $urandom_range(0, 15) == 0, 1'($urandom), "rand");
    end

    apply(2'b11, 5, 5, 8'hC1, 8'hC2, 1'b0, 1'b1, "burst0");
    wren      = 2'b11;
    wraddr    = {AW'(5), AW'(5)};
    wrdata    = {8'hD2, 8'hD1};
    collision = 1'b1;
    clr_stat  = 1'b0;
    #2;
    aresetn = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(posedge aclk);
    #1;
    check_zero("rst_edge");
    @(negedge aclk);
    aresetn = 1'b1;
    apply(2'b10, 0, 5, 0, 8'h3C, 1'b0, 1'b0, "post_rst");
    chk("post_rst.const_ack", 32'(wrack), 32'h2);
    apply(2'b11, 5, 5, 8'hE0, 8'hE1, 1'b0, 1'b1, "post_rst_coll");
    chk("post_rst_coll.const_ack", 32'(wrack), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
